nco_quad: RTL and testbench



---
 rtl/nco_quad.sv | 125 ++++++++++++
 tb/tb_nco_quad.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/nco_quad.sv
// Quadrature phase-accumulator NCO: 24-bit accumulator, truncated phase with offset,
// quarter-wave sine table built at elaboration, registered sin/cos and fill-based valid.
module nco_quad #(
  parameter int unsigned gp_acc_width   = 24,
  parameter int unsigned gp_phase_width = 10,
  parameter int unsigned gp_oup_width   = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_an,
  input  logic                      i_ena,
  input  logic                      i_sync,
  input  logic [gp_acc_width-1:0]   i_fcw,
  input  logic [gp_phase_width-1:0] i_pow,
  output logic [gp_oup_width-1:0]   o_sin,
  output logic [gp_oup_width-1:0]   o_cos,
  output logic                      o_vld
);

  localparam int unsigned AccW  = gp_acc_width;
  localparam int unsigned P     = gp_phase_width;
  localparam int unsigned W     = gp_oup_width;
  localparam int unsigned AW    = P - 2;
  localparam int unsigned Depth = 2 ** AW;
  localparam real         Pi    = 3.14159265358979323846;

  // Taylor series; only ever evaluated on [0, pi/2), where 12 terms are far below 1 LSB.
  function automatic real sin_series(input real x);
    real term;
    real sum;
    term = x;
    sum  = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic logic [W-1:0] tbl_val(input int k);
    real amp;
    real ang;
    real v;
    amp = (2.0 ** (W - 1)) - 1.0;
    ang = 2.0 * Pi * (real'(k) + 0.5) / (2.0 ** P);
    v   = amp * sin_series(ang);
    return W'($rtoi(v + 0.5));
  endfunction

  logic [W-1:0] tbl [Depth];

  for (genvar k = 0; k < Depth; k++) begin : g_tbl
    localparam logic [W-1:0] TVal = tbl_val(k);
    assign tbl[k] = TVal;
  end

  logic [AccW-1:0] acc_q, acc_d;
  logic [P-1:0]    ph_q, ph_d;
  logic [W-1:0]    ta_q, ta_d;
  logic [W-1:0]    tna_q, tna_d;
  logic [1:0]      quad_q, quad_d;
  logic [W-1:0]    sin_q, sin_d;
  logic [W-1:0]    cos_q, cos_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            vld_q, vld_d;

  logic [AW-1:0]   addr;
  logic [AW-1:0]   addr_n;
  logic [W-1:0]    sin_mag;
  logic [W-1:0]    cos_mag;

  always_comb begin
    acc_d   = i_sync ? '0 : acc_q + i_fcw;
    ph_d    = acc_q[AccW-1 -: P] + i_pow;

    addr    = ph_q[AW-1:0];
    addr_n  = ~addr;
    ta_d    = tbl[addr];
    tna_d   = tbl[addr_n];
    quad_d  = ph_q[P-1 -: 2];

    // Odd quadrants read the mirrored entry; sign follows the quadrant's half-wave.
    sin_mag = quad_q[0] ? tna_q : ta_q;
    cos_mag = quad_q[0] ? ta_q : tna_q;
    sin_d   = quad_q[1] ? -sin_mag : sin_mag;
    cos_d   = (quad_q[1] ^ quad_q[0]) ? -cos_mag : cos_mag;

    if (i_sync) begin
      cnt_d = 2'd0;
    end else if (cnt_q == 2'd3) begin
      cnt_d = 2'd3;
    end else begin
      cnt_d = cnt_q + 2'd1;
    end
    vld_d = (cnt_d == 2'd3);
  end

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      acc_q  <= '0;
      ph_q   <= '0;
      ta_q   <= '0;
      tna_q  <= '0;
      quad_q <= '0;
      sin_q  <= '0;
      cos_q  <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
    end else if (i_ena) begin
      acc_q  <= acc_d;
      ph_q   <= ph_d;
      ta_q   <= ta_d;
      tna_q  <= tna_d;
      quad_q <= quad_d;
      sin_q  <= sin_d;
      cos_q  <= cos_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
    end
  end

  assign o_sin = sin_q;
  assign o_cos = cos_q;
  assign o_vld = vld_q;

endmodule

// File: tb/tb_nco_quad.sv
// Scoreboard bench for nco_quad: a behavioural model queues the expected sample per edge,
// a negedge monitor compares, and directed spot checks pin hand-computed values.
module tb_nco_quad;

  localparam int  AccW = 24;
  localparam int  P    = 10;
  localparam int  W    = 16;
  localparam real PI   = 3.14159265358979323846;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          sync;
  logic [23:0]   fcw;
  logic [9:0]    pow;
  logic [15:0]   sin_o;
  logic [15:0]   cos_o;
  logic          vld;

  always #5 clk = ~clk;

  nco_quad #(
    .gp_acc_width  (AccW),
    .gp_phase_width(P),
    .gp_oup_width  (W)
  ) dut (
    .i_clk   (clk),
    .i_rst_an(rst_n),
    .i_ena   (ena),
    .i_sync  (sync),
    .i_fcw   (fcw),
    .i_pow   (pow),
    .o_sin   (sin_o),
    .o_cos   (cos_o),
    .o_vld   (vld)
  );

  typedef struct {
    logic vld;
    logic known;
    int   s;
    int   c;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [23:0] acc_m;
  logic [9:0]  ph0_m;
  logic [9:0]  ph1_m;
  int          cnt_m;
  exp_t        cur_m;

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  function automatic int ref_sin(input logic [9:0] ph);
    return rnd(32767.0 * $sin(2.0 * PI * (real'(ph) + 0.5) / 1024.0));
  endfunction

  function automatic int ref_cos(input logic [9:0] ph);
    return rnd(32767.0 * $cos(2.0 * PI * (real'(ph) + 0.5) / 1024.0));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    acc_m = '0;
    ph0_m = '0;
    ph1_m = '0;
    cnt_m = 0;
    cur_m = '{vld: 1'b0, known: 1'b1, s: 0, c: 0};
    sb.delete();
  endtask

  // Called at each posedge with the inputs the DUT just sampled.
  task automatic model_edge();
    logic [9:0] ph_new;
    logic [9:0] out_ph;
    if (ena) begin
      ph_new = acc_m[23:14] + pow;
      out_ph = ph1_m;
      ph1_m  = ph0_m;
      ph0_m  = ph_new;
      acc_m  = sync ? 24'd0 : acc_m + fcw;
      cnt_m  = sync ? 0 : ((cnt_m < 3) ? cnt_m + 1 : 3);
      cur_m.vld   = (cnt_m == 3);
      cur_m.known = cur_m.vld;
      cur_m.s     = ref_sin(out_ph);
      cur_m.c     = ref_cos(out_ph);
    end
    sb.push_back(cur_m);
  endtask

  task automatic drive(input logic e, input logic s, input logic [23:0] f, input logic [9:0] p);
    ena  = e;
    sync = s;
    fcw  = f;
    pow  = p;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk_out(input string name, input int s, input int c, input int v);
    chk({name, "_sin"}, int'($signed(sin_o)), s);
    chk({name, "_cos"}, int'($signed(cos_o)), c);
    chk({name, "_vld"}, int'(vld), v);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_vld", int'(vld), int'(e.vld));
        if (e.known) begin
          chk("sb_sin", int'($signed(sin_o)), e.s);
          chk("sb_cos", int'($signed(cos_o)), e.c);
        end
      end
    end
  end

  initial begin : stim
    rst_n = 1'b1;
    ena   = 1'b0;
    sync  = 1'b0;
    fcw   = '0;
    pow   = '0;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", 0, 0, 0);
    rst_n = 1'b1;

    repeat (10) drive(1'b0, 1'b0, 24'd0, 10'd0);
    chk_out("ena_low_after_reset", 0, 0, 0);

    // Ramp: one phase step per edge, output phase k-3 after the k-th edge past sync.
    drive(1'b1, 1'b1, 24'h004000, 10'd0);
    for (int k = 1; k <= 1030; k++) begin
      drive(1'b1, 1'b0, 24'h004000, 10'd0);
      if (k == 3)   chk_out("ramp_ph0", 101, 32767, 1);
      if (k == 259) chk_out("ramp_ph256", 32767, -101, 1);
      if (k == 515) chk_out("ramp_ph512", -101, -32767, 1);
    end

    repeat (5) drive(1'b0, 1'b0, 24'h004000, 10'd0);
    repeat (20) drive(1'b1, 1'b0, 24'h004000, 10'd0);

    drive(1'b1, 1'b1, 24'h004000, 10'd0);
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 1'b0, 24'h004000, 10'd0);
      chk("sync_vld", int'(vld), (k == 3) ? 1 : 0);
    end
    chk("sync_restart_sin", int'($signed(sin_o)), 101);
    repeat (5) drive(1'b1, 1'b0, 24'h004000, 10'd0);

    // Half-rate: fcw changes on the sync edge itself.
    drive(1'b1, 1'b1, 24'h800000, 10'd0);
    for (int k = 1; k <= 12; k++) begin
      drive(1'b1, 1'b0, 24'h800000, 10'd0);
      if (k >= 3) begin
        if (((k - 3) % 2) == 0) chk_out("half_even", 101, 32767, 1);
        else                    chk_out("half_odd", -101, -32767, 1);
      end
    end

    drive(1'b1, 1'b1, 24'd0, 10'd256);
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 1'b0, 24'd0, 10'd256);
      if (k >= 3) chk_out("pow256", 32767, -101, 1);
    end
    drive(1'b1, 1'b0, 24'd0, 10'd768);
    chk_out("pow_chg_e0", 32767, -101, 1);
    drive(1'b1, 1'b0, 24'd0, 10'd768);
    chk_out("pow_chg_e1", 32767, -101, 1);
    drive(1'b1, 1'b0, 24'd0, 10'd768);
    chk_out("pow_chg_e2", -32767, 101, 1);

    repeat (6) drive(1'b1, 1'b0, 24'h004000, 10'd256);
    #3;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk_out("async_rst", 0, 0, 0);
    @(posedge clk);
    #1;
    chk_out("async_rst_hold", 0, 0, 0);
    model_reset();
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 1'b0, 24'h004000, 10'd0);
      if (k == 3) chk_out("post_rst_ph0", 101, 32767, 1);
    end

    @(negedge clk);
    #1;
    chk("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
